// File: rtl/avgp_3x3_seq_ctrl.sv
// Sequencer for the 3x3 average-pooling pipeline: streams one feature map from memory into the
// pipeline, writes results back at linear addresses and flags a stalled drain with a watchdog.
module avgp_3x3_seq_ctrl #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned IMAGE_WIDTH    = 16,
  parameter int unsigned IMAGE_HEIGHT   = 16,
  parameter int unsigned CHANNEL_NUM_IN = 512,
  parameter int unsigned IN_COUNT       = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM_IN,
  parameter int unsigned OUT_COUNT      = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM_IN,
  parameter int unsigned ADDR_WIDTH     = 18,
  parameter int unsigned TIMEOUT        = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  hold_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  pool_valid_in_o,
  output logic [DATA_WIDTH-1:0] pool_pxl_in_o,
  input  logic                  pool_valid_out_i,
  input  logic [DATA_WIDTH-1:0] pool_pxl_out_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int unsigned WdWidth = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LastRd = ADDR_WIDTH'(IN_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] LastWr = ADDR_WIDTH'(OUT_COUNT - 1);
  localparam logic [WdWidth-1:0]    WdLast = WdWidth'(TIMEOUT - 1);
  localparam logic [WdWidth-1:0]    WdMax  = WdWidth'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                  state_q, state_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                    valid_in_q;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0]   out_cnt_q, out_cnt_d;
  logic [WdWidth-1:0]      wd_q, wd_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    accept;

  // done_q keeps the FSM in DRAIN for the pulse cycle, so busy falls one cycle after done
  // and no result is taken after the final write or a timeout.
  assign accept = pool_valid_out_i && (state_q != StIdle) && !done_q;

  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    out_cnt_d = out_cnt_q;
    wd_d      = wd_q;
    done_d    = 1'b0;
    error_d   = error_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StIssue;
          rd_en_d   = !hold_i;
          rd_addr_d = '0;
          wr_addr_d = '0;
          out_cnt_d = '0;
          wd_d      = '0;
          error_d   = 1'b0;
        end
      end
      StIssue: begin
        if (rd_en_q && (rd_addr_q == LastRd)) begin
          state_d = StDrain;
        end else begin
          if (rd_en_q) rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          rd_en_d = !hold_i;
        end
      end
      StDrain: begin
        if (done_q) begin
          state_d = StIdle;
        end else if (pool_valid_out_i) begin
          wd_d = '0;
        end else begin
          if (wd_q == WdLast) begin
            done_d  = 1'b1;
            error_d = 1'b1;
          end
          if (wd_q != WdMax) wd_d = wd_q + WdWidth'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      wr_en_d   = 1'b1;
      wr_addr_d = out_cnt_q;
      wr_data_d = pool_pxl_out_i;
      out_cnt_d = out_cnt_q + ADDR_WIDTH'(1);
      if ((state_q == StDrain) && (out_cnt_q == LastWr)) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      valid_in_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      out_cnt_q  <= '0;
      wd_q       <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      valid_in_q <= rd_en_q;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      out_cnt_q  <= out_cnt_d;
      wd_q       <= wd_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rd_en_o         = rd_en_q;
  assign rd_addr_o       = rd_addr_q;
  assign pool_valid_in_o = valid_in_q;
  assign pool_pxl_in_o   = valid_in_q ? mem_rdata_i : '0;
  assign wr_en_o         = wr_en_q;
  assign wr_addr_o       = wr_addr_q;
  assign wr_data_o       = wr_data_q;
  assign busy_o          = (state_q != StIdle);
  assign done_o          = done_q;
  assign error_o         = error_q;

endmodule
